ipv4_header_checker: RTL and testbench
======================================

IPV4_HEADER_CHECKER -- requirements
Module: ipv4_header_checker

Interface
REQ-001 SHALL have parameter CHECK_VERSION, default 1, meaning that version field != 4 is flagged as an error (0 = version not checked).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port hdr_tdata  input  32  header/packet word, big-endian (tdata[31:24] = first byte on the wire).
REQ-005 SHALL have port hdr_tvalid  input  1  word valid.
REQ-006 SHALL have port hdr_tlast  input  1  last word of packet.
REQ-007 SHALL have port hdr_tready  output  1  tied to 1'b1; backpressure is not supported.
REQ-008 SHALL have port res_valid  output  1  single-cycle result strobe.
REQ-009 SHALL have port res_ok  output  1  header passed all checks.
REQ-010 SHALL have port res_err  output  4  {short, bad_ihl, bad_version, bad_checksum}, MSB first.
REQ-011 SHALL have port res_ihl  output  4  IHL field of the checked header.

Function
REQ-012 SHALL accept a word on every cycle with hdr_tvalid=1; word count k starts at 0 on the first word after reset or after a tlast.
REQ-013 SHALL capture IHL = word0[27:24] and version = word0[31:28].
REQ-014 SHALL use states IDLE (expect word0), ACCUM (summing header words), DRAIN (discard until tlast).
REQ-015 IDLE: on word0, SHALL go to ACCUM if 5<=IHL<=15 and tlast=0; to DRAIN if IHL<5 and tlast=0; stay in IDLE if tlast=1.
REQ-016 ACCUM: SHALL add both 16-bit halves of each word k < IHL, including word0 and the stored checksum field, into a 21-bit unsigned accumulator (30 halfwords max, no overflow).
REQ-017 ACCUM: on word k = IHL-1, SHALL go to DRAIN if tlast=0, else to IDLE.
REQ-018 ACCUM: on tlast with k < IHL-1, SHALL end the packet with short=1 and go to IDLE.
REQ-019 DRAIN: SHALL ignore words (payload or trailing) and go to IDLE on tlast.
REQ-020 Fold: sum16 = acc[15:0] + acc[20:16], then sum16[15:0] + carry; bad_checksum = (folded != 16'hFFFF).
REQ-021 bad_version = CHECK_VERSION && version != 4; bad_ihl = IHL < 5; bad_ihl suppresses the checksum check (bad_checksum=0).
REQ-022 short SHALL be set when tlast arrives before IHL words (including tlast on word0 with IHL>=5).
REQ-023 res_ok SHALL be 1 iff res_err == 4'b0000.
REQ-024 Result trigger: the handshake cycle N of word IHL-1, of a short-terminating tlast, or of word0 when IHL<5.
REQ-025 res_valid SHALL be high exactly in cycle N+2 (stage 1: final accumulate; stage 2: fold/compare, registered); exactly one result per packet.
REQ-026 res_ok/res_err/res_ihl SHALL be valid only while res_valid=1 and hold their last values otherwise.
REQ-027 A new packet's word0 SHALL be accepted the cycle after a tlast with no bubble; back-to-back results SHALL not be lost (the pipeline is fully pipelined).
REQ-028 A tlast in DRAIN SHALL produce no result; words with hdr_tvalid=0 SHALL not advance k or the state.

Reset
REQ-029 While aresetn=0: state=IDLE, k=0, acc=0, res_valid=0, res_ok=0, res_err=0, res_ihl=0, and in-flight pipeline stages cleared.
REQ-030 Reset mid-packet SHALL discard the partial packet with no result; the first word after release SHALL be treated as word0.

Verification
REQ-031 Valid header 45000073 00004000 4011B861 C0A80001 C0A800C7 (tlast on word 4) -> res_valid at N+2, res_ok=1, res_err=0000, res_ihl=5.
REQ-032 Same header with B861 replaced by B862 -> res_ok=0, res_err=0001; 5 header words + 3 payload words, tlast on word 7 -> exactly one result, at the word-4 cycle +2.
REQ-033 IHL=6 header with option word 01010101 and model-computed checksum -> res_ok=1; the same header with tlast on word 2 -> res_err=1000.
REQ-034 Word0 = 44000014 -> res_err=0100 two cycles after word0, subsequent words ignored until tlast; word0 = 65000014 with CHECK_VERSION=1 -> bad_version bit set.
REQ-035 aresetn pulsed low after word 2 of a packet, then the valid header of REQ-031 -> no spurious result, then res_ok=1.
REQ-036 Two valid headers back-to-back with continuous hdr_tvalid -> two res_valid pulses exactly 5 cycles apart, both res_ok=1.

Source files
------------

// File: rtl/ipv4_header_checker.sv
// Streaming IPv4 header checker: sums the header halfwords as they arrive, then folds
// and compares in a two-stage result pipeline. One result strobe per packet.
module ipv4_header_checker #(
    parameter int CHECK_VERSION = 1
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] hdr_tdata,
    input  logic        hdr_tvalid,
    input  logic        hdr_tlast,
    output logic        hdr_tready,
    output logic        res_valid,
    output logic        res_ok,
    output logic [3:0]  res_err,
    output logic [3:0]  res_ihl,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

    state_t      state;
    logic [3:0]  k;
    logic [3:0]  ihl;
    logic        ver_bad;
    logic [20:0] acc;

    logic        s1_valid;
    logic [20:0] s1_acc;
    logic [3:0]  s1_ihl;
    logic        s1_short;
    logic        s1_bad_ihl;
    logic        s1_bad_ver;

    logic [3:0]  w_ihl;
    logic        w_ver_bad;
    logic [16:0] halves;
    logic [20:0] acc_next;
    logic [16:0] fold1;
    logic [15:0] folded;
    logic        bad_cs;
    logic [3:0]  err;

    // Handshake: a word transfers on every rising edge with hdr_tvalid=1; hdr_tready is constant 1.
    assign hdr_tready = 1'b1;
    assign state_dbg  = state;

    assign w_ihl     = hdr_tdata[27:24];
    assign w_ver_bad = (CHECK_VERSION != 0) && (hdr_tdata[31:28] != 4'd4);
    assign halves    = {1'b0, hdr_tdata[31:16]} + {1'b0, hdr_tdata[15:0]};
    assign acc_next  = acc + {4'd0, halves};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            k          <= 4'd0;
            ihl        <= 4'd0;
            ver_bad    <= 1'b0;
            acc        <= 21'd0;
            s1_valid   <= 1'b0;
            s1_acc     <= 21'd0;
            s1_ihl     <= 4'd0;
            s1_short   <= 1'b0;
            s1_bad_ihl <= 1'b0;
            s1_bad_ver <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (hdr_tvalid) begin
                case (state)
                    IDLE: begin
                        ihl     <= w_ihl;
                        ver_bad <= w_ver_bad;
                        k       <= 4'd0;
                        acc     <= 21'd0;
                        if (w_ihl < 4'd5) begin
                            s1_valid   <= 1'b1;
                            s1_acc     <= 21'd0;
                            s1_ihl     <= w_ihl;
                            s1_short   <= 1'b0;
                            s1_bad_ihl <= 1'b1;
                            s1_bad_ver <= w_ver_bad;
                            state      <= hdr_tlast ? IDLE : DRAIN;
                        end else if (hdr_tlast) begin
                            s1_valid   <= 1'b1;
                            s1_acc     <= 21'd0;
                            s1_ihl     <= w_ihl;
                            s1_short   <= 1'b1;
                            s1_bad_ihl <= 1'b0;
                            s1_bad_ver <= w_ver_bad;
                        end else begin
                            acc   <= {4'd0, halves};
                            k     <= 4'd1;
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (k == ihl - 4'd1 || hdr_tlast) begin
                            // The last header word is folded into the sum on its way to stage 1.
                            s1_valid   <= 1'b1;
                            s1_acc     <= acc_next;
                            s1_ihl     <= ihl;
                            s1_short   <= (k != ihl - 4'd1);
                            s1_bad_ihl <= 1'b0;
                            s1_bad_ver <= ver_bad;
                            k          <= 4'd0;
                            state      <= (k == ihl - 4'd1 && !hdr_tlast) ? DRAIN : IDLE;
                        end else begin
                            acc <= acc_next;
                            k   <= k + 4'd1;
                        end
                    end
                    DRAIN: begin
                        if (hdr_tlast) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A truncated or malformed header carries no meaningful checksum.
    assign fold1  = {1'b0, s1_acc[15:0]} + {12'd0, s1_acc[20:16]};
    assign folded = fold1[15:0] + {15'd0, fold1[16]};
    assign bad_cs = !s1_short && !s1_bad_ihl && (folded != 16'hFFFF);
    assign err    = {s1_short, s1_bad_ihl, s1_bad_ver, bad_cs};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_err   <= 4'd0;
            res_ihl   <= 4'd0;
        end else begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_ok  <= (err == 4'd0);
                res_err <= err;
                res_ihl <= s1_ihl;
            end
        end
    end

endmodule

// File: tb/tb_ipv4_header_checker.sv
// Bench for ipv4_header_checker: a packet-level model predicts each result and its cycle,
// a negedge compare process checks every cycle, directed tests pin literal results.
module tb_ipv4_header_checker;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] hdr_tdata = 32'd0;
    logic        hdr_tvalid = 1'b0;
    logic        hdr_tlast = 1'b0;
    logic        hdr_tready;
    logic        res_valid;
    logic        res_ok;
    logic [3:0]  res_err;
    logic [3:0]  res_ihl;
    logic [1:0]  state_dbg;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int res_count = 0;
    int res_cyc_q[$];

    logic [40:0] exp_q[$];
    logic [31:0] mq[$];
    bit          trig = 1'b0;
    logic        hold_ok = 1'b0;
    logic [3:0]  hold_err = 4'd0;
    logic [3:0]  hold_ihl = 4'd0;

    logic [31:0] pkt[0:15];

    ipv4_header_checker #(.CHECK_VERSION(1)) dut (
        .clk(clk), .aresetn(aresetn), .hdr_tdata(hdr_tdata), .hdr_tvalid(hdr_tvalid),
        .hdr_tlast(hdr_tlast), .hdr_tready(hdr_tready), .res_valid(res_valid),
        .res_ok(res_ok), .res_err(res_err), .res_ihl(res_ihl), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] onesum(input logic [31:0] q[$]);
        int unsigned s = 0;
        foreach (q[i]) s += q[i][31:16] + q[i][15:0];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    // Model: collect the packet, decide from word index alone when the result is due.
    task automatic predict(input bit short_pkt);
        int  ihl_i = int'(mq[0][27:24]);
        bit  b_ihl = (ihl_i < 5);
        bit  b_ver = (mq[0][31:28] != 4'd4);
        bit  b_cs = !short_pkt && !b_ihl && (onesum(mq) != 16'hFFFF);
        logic [3:0] e = {short_pkt, b_ihl, b_ver, b_cs};
        exp_q.push_back({32'(cyc + 1), (e == 4'd0), e, mq[0][27:24]});
        trig = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!aresetn) begin
            mq.delete();
            exp_q.delete();
            trig = 1'b0;
        end else if (hdr_tvalid) begin
            mq.push_back(hdr_tdata);
            if (!trig) begin
                if (mq[0][27:24] < 4'd5) predict(1'b0);
                else if (mq.size() == int'(mq[0][27:24])) predict(1'b0);
                else if (hdr_tlast) predict(1'b1);
            end
            if (hdr_tlast) begin
                mq.delete();
                trig = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [40:0] e;
        if (!aresetn) begin
            check("rst_valid", 32'(res_valid), 32'd0);
            check("rst_ok", 32'(res_ok), 32'd0);
            check("rst_err", 32'(res_err), 32'd0);
            check("rst_ihl", 32'(res_ihl), 32'd0);
            hold_ok = 1'b0; hold_err = 4'd0; hold_ihl = 4'd0;
        end else begin
            if (exp_q.size() > 0 && int'(exp_q[0][40:9]) < cyc) begin
                e = exp_q.pop_front();
                check("missing_result", 32'(cyc), e[40:9]);
            end
            if (res_valid) begin
                res_count++;
                res_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_cycle", 32'(cyc), e[40:9]);
                    check("res_ok", 32'(res_ok), 32'(e[8]));
                    check("res_err", 32'(res_err), 32'(e[7:4]));
                    check("res_ihl", 32'(res_ihl), 32'(e[3:0]));
                    hold_ok = e[8]; hold_err = e[7:4]; hold_ihl = e[3:0];
                end
            end else begin
                check("hold", {23'd0, res_ok, res_err, res_ihl}, {23'd0, hold_ok, hold_err, hold_ihl});
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic v, input logic l);
        hdr_tdata = d; hdr_tvalid = v; hdr_tlast = l;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive($urandom, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Sends pkt[0..n-1]; tlast on the final word when with_last is set.
    task automatic send(input int n, input bit with_last, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) idle(1);
            drive(pkt[i], 1'b1, with_last && (i == n - 1));
        end
        hdr_tvalid = 1'b0;
        hdr_tlast = 1'b0;
    endtask

    task automatic load_valid();
        pkt[0] = 32'h45000073; pkt[1] = 32'h00004000; pkt[2] = 32'h4011B861;
        pkt[3] = 32'hC0A80001; pkt[4] = 32'hC0A800C7;
    endtask

    initial begin
        int base;
        logic [31:0] hq[$];
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        idle(2);

        // Reference header with correct checksum
        base = res_count;
        load_valid();
        send(5, 1'b1, 1'b0);
        idle(3);
        check("v_count", 32'(res_count - base), 32'd1);
        check("v_ok", 32'(res_ok), 32'd1);
        check("v_err", 32'(res_err), 32'd0);
        check("v_ihl", 32'(res_ihl), 32'd5);

        // Corrupt checksum, with payload
        base = res_count;
        pkt[2] = 32'h4011B862;
        pkt[5] = 32'hDEADBEEF; pkt[6] = 32'h01234567; pkt[7] = 32'h89ABCDEF;
        send(8, 1'b1, 1'b0);
        idle(3);
        check("cs_count", 32'(res_count - base), 32'd1);
        check("cs_ok", 32'(res_ok), 32'd0);
        check("cs_err", 32'(res_err), 32'b0001);

        // IHL=6 with one option word
        pkt[0] = 32'h46000018; pkt[1] = 32'h00004000; pkt[2] = 32'h40110000;
        pkt[3] = 32'hC0A80001; pkt[4] = 32'hC0A800C7; pkt[5] = 32'h01010101;
        hq.delete();
        for (int i = 0; i < 6; i++) hq.push_back(pkt[i]);
        pkt[2][15:0] = ~onesum(hq);
        send(6, 1'b1, 1'b0);
        idle(3);
        check("ihl6_ok", 32'(res_ok), 32'd1);
        check("ihl6_ihl", 32'(res_ihl), 32'd6);
        send(3, 1'b1, 1'b0);
        idle(3);
        check("short_err", 32'(res_err), 32'b1000);
        check("short_ihl", 32'(res_ihl), 32'd6);

        // IHL=4: reported two cycles after word0, rest ignored
        base = res_count;
        pkt[0] = 32'h44000014;
        for (int i = 1; i < 5; i++) pkt[i] = $urandom;
        send(5, 1'b1, 1'b0);
        idle(3);
        check("ihl4_count", 32'(res_count - base), 32'd1);
        check("ihl4_err", 32'(res_err), 32'b0100);
        check("ihl4_ihl", 32'(res_ihl), 32'd4);

        // Version 6
        load_valid();
        pkt[0] = 32'h65000073;
        send(5, 1'b1, 1'b0);
        idle(3);
        check("ver_bit", 32'(res_err[1]), 32'd1);

        // tlast on word0 with IHL=5
        load_valid();
        send(1, 1'b1, 1'b0);
        idle(3);
        check("w0last_err", 32'(res_err), 32'b1000);

        // Valid header with idle gaps
        load_valid();
        send(5, 1'b1, 1'b1);
        idle(3);
        check("gap_ok", 32'(res_ok), 32'd1);

        // Reset after word 2, then the valid header
        base = res_count;
        send(3, 1'b0, 1'b0);
        aresetn = 1'b0;
        idle(2);
        aresetn = 1'b1;
        idle(1);
        check("rst_none", 32'(res_count - base), 32'd0);
        send(5, 1'b1, 1'b0);
        idle(3);
        check("rst_after_count", 32'(res_count - base), 32'd1);
        check("rst_after_ok", 32'(res_ok), 32'd1);

        // Two valid headers back to back
        base = res_count;
        res_cyc_q.delete();
        send(5, 1'b1, 1'b0);
        send(5, 1'b1, 1'b0);
        idle(4);
        check("b2b_count", 32'(res_count - base), 32'd2);
        if (res_cyc_q.size() == 2) check("b2b_gap", 32'(res_cyc_q[1] - res_cyc_q[0]), 32'd5);
        else check("b2b_pulses", 32'(res_cyc_q.size()), 32'd2);
        check("b2b_ok", 32'(res_ok), 32'd1);

        idle(4);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
